alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Initiator side of the 32-bit ALU operand interface (in1/in2/funct3/funct7 -> out). Accepts RV32I
//  OP/OP-IMM instructions via valid/ready, reads operands from an internal register file, and drives
//  the ALU port registered. It captures the ALU result and writes it back to rd. This is the
//  decode/issue/writeback shell around the combinational ALU in the single-issue NPC core.
// PARAMETERS
//  NR_REGS     32  architectural registers (16 for RV32E; rs/rd index >= NR_REGS -> illegal)
//  RESET_REGS  1   1: synchronous reset clears every register to 0; 0: only FSM/outputs reset
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst           in   1   reset, synchronous, active-high
//  inst_valid    in   1   instruction offered
//  inst          in   32  RV32 instruction word
//  inst_ready    out  1   block can accept (high only in IDLE)
//  alu_in1       out  32  ALU operand 1 (registered)
//  alu_in2       out  32  ALU operand 2 (registered)
//  alu_funct3    out  3   ALU operation select (registered)
//  alu_funct7    out  7   ALU sub-select (registered)
//  alu_out       in   32  ALU result, combinational from the alu_* outputs
//  retire_valid  out  1   one-cycle pulse: instruction written back
//  retire_rd     out  5   destination index of retired instruction
//  retire_data   out  32  value written (0 when rd==x0)
//  illegal       out  1   one-cycle pulse: accepted word not a legal OP/OP-IMM
//  dbg_raddr     in   5   debug read index
//  dbg_rdata     out  32  register value, combinational; x0 reads 0
// BEHAVIOUR
//  Reset: state IDLE; inst_ready=1; alu_*=0; retire_valid=0, retire_rd=0, retire_data=0; illegal=0.
//   A reset mid-operation aborts: no writeback, no retire, no illegal pulse.
//  FSM IDLE -> EXEC -> WB -> IDLE, one instruction in flight, no overlap.
//   IDLE: inst_ready=1; inst_valid&inst_ready accepts. A legal word goes to EXEC with alu_* loaded.
//    An illegal word asserts illegal for the next cycle and stays IDLE. No reg or alu_* change.
//   EXEC: alu_* stable; alu_out is sampled at the end of this cycle into the result register.
//   WB: rf[rd]<=result unless rd==0; retire_valid=1 with rd/data this cycle; next state IDLE.
//  Latency: accept at cycle N -> retire_valid at N+2; throughput 1 per 3 cycles.
//  Decode, opcode inst[6:0]:
//   0110011 OP: in1=rf[rs1], in2=rf[rs2], funct3=inst[14:12], funct7=inst[31:25].
//    Legal if funct7==00, or funct7==20 with funct3 in {0,5}.
//   0010011 OP-IMM: in1=rf[rs1], in2=sext(inst[31:20]).
//    funct3 in {1,5}: funct7=inst[31:25]. Legal if f3=1&f7=00, or f3=5&f7 in {00,20}.
//    Otherwise funct7 forced 00, always legal (ADDI with imm[10]=1 must not become SUB).
//   Any other opcode -> illegal. rs/rd index >= NR_REGS -> illegal.
//  Operand read in IDLE sees writes completed in all earlier cycles. There is no same-cycle
//   hazard, because WB and accept never coincide.
//  x0 reads 0 always; a write to x0 is dropped, but still retires with retire_rd=0, retire_data=0.
//  inst_valid with inst_ready=0 is impossible by protocol. If inst_valid is held high, a new
//   word is accepted on the cycle the FSM returns to IDLE.
//  All arithmetic is modulo 2^32 and performed by the external ALU; this block does no
//   arithmetic itself.
// STRUCTURE
//  Shared package alu_pkg:
//   OPC_OP=7'b0110011, OPC_OPIMM=7'b0010011, F7_BASE=7'h00, F7_ALT=7'h20.
//   F3_ADD=0, F3_SLL=1, F3_SLT=2, F3_SLTU=3, F3_XOR=4, F3_SR=5, F3_OR=6, F3_AND=7.
//   FSM encodings ST_IDLE/ST_EXEC/ST_WB (2 bits).
//  Sub-module rv_regfile: NR_REGS x 32 registers; two async read ports (rs1, rs2), one debug
//   async read port, one sync write port; x0 hardwired to 0; RESET_REGS honoured.
//  Decode and legality checks are combinational in this module; alu_* and the result register
//   are flops.
// TESTING
//  1 rst 2 cycles; dbg every reg -> 0; inst_ready=1, retire_valid=0, illegal=0.
//  2 ADDI x1,x0,5 then ADDI x2,x0,-3:
//    -> retire x1=0x00000005 and x2=0xFFFFFFFD, each 2 cycles after its accept.
//  3 SUB x3,x1,x2 -> alu_funct7=0x20, x3=0x00000008.
//    SLT x4,x2,x1 -> 1. SLTU x5,x2,x1 -> 0.
//  4 ADDI x6,x0,0x400 (imm bit 10 set) -> alu_funct7=00, x6=0x00000400.
//    SRAI x7,x2,1 -> funct7=0x20, x7=0xFFFFFFFE.
//  5 Illegal words -> illegal pulse 1 cycle, no retire, regs unchanged:
//    SLLI with funct7=0x20; OP with funct7=0x01 (MUL); opcode 0x37 (LUI).
//  6 ADDI x0,x0,7 -> retire rd=0 data=0, dbg x0=0.
//    rst asserted in EXEC -> no retire, state IDLE, target reg unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue shell: opcodes, funct fields and FSM states.
package alu_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/rv_regfile.sv
// Architectural register file: two operand read ports, one debug read port,
// one synchronous write port. x0 and out-of-range indices read as zero.
module rv_regfile #(
  parameter int NR_REGS    = 32,
  parameter int RESET_REGS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  output logic [31:0] rs1_data,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs2_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  localparam int AW = (NR_REGS > 1) ? $clog2(NR_REGS) : 1;

  logic [31:0] regs [NR_REGS];

  assign rs1_data = (rs1_addr != '0 && int'(rs1_addr) < NR_REGS) ? regs[rs1_addr[AW-1:0]] : '0;
  assign rs2_data = (rs2_addr != '0 && int'(rs2_addr) < NR_REGS) ? regs[rs2_addr[AW-1:0]] : '0;
  assign dbg_data = (dbg_addr != '0 && int'(dbg_addr) < NR_REGS) ? regs[dbg_addr[AW-1:0]] : '0;

  // Clear on reset when enabled; writes to x0 are dropped
  always_ff @(posedge clk) begin
    if (rst && RESET_REGS != 0) begin
      for (int i = 0; i < NR_REGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0 && int'(waddr) < NR_REGS) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Decode/issue/writeback shell around an external combinational ALU.
// One instruction in flight: IDLE (accept) -> EXEC (ALU settles) -> WB (retire).
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NR_REGS    = 32,
  parameter int RESET_REGS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  output logic        inst_ready,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  input  logic [31:0] alu_out,
  output logic        retire_valid,
  output logic [4:0]  retire_rd,
  output logic [31:0] retire_data,
  output logic        illegal,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  state_e      state, state_nxt;
  logic [31:0] result;
  logic [4:0]  rd_q;

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_data, rs2_data;
  logic        d_legal;
  logic [31:0] d_in2;
  logic [6:0]  d_f7;
  logic        accept;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign f7     = inst[31:25];
  assign accept = (state == ST_IDLE) && inst_valid;

  function automatic logic idx_ok(input logic [4:0] idx);
    return int'(idx) < NR_REGS;
  endfunction

  rv_regfile #(.NR_REGS(NR_REGS), .RESET_REGS(RESET_REGS)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs1_data (rs1_data),
    .rs2_addr (rs2),
    .rs2_data (rs2_data),
    .dbg_addr (dbg_raddr),
    .dbg_data (dbg_rdata),
    .we       (retire_valid),
    .waddr    (rd_q),
    .wdata    (result)
  );

  // Decode and legality; non-shift OP-IMM forces funct7 to BASE so ADDI never turns into SUB
  always_comb begin
    d_legal = 1'b0;
    d_in2   = rs2_data;
    d_f7    = f7;
    case (opcode)
      OPC_OP: d_legal = (f7 == F7_BASE) || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
      OPC_OPIMM: begin
        d_in2 = {{20{inst[31]}}, inst[31:20]};
        if (f3 == F3_SLL)     d_legal = (f7 == F7_BASE);
        else if (f3 == F3_SR) d_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        else begin
          d_f7    = F7_BASE;
          d_legal = 1'b1;
        end
      end
      default: d_legal = 1'b0;
    endcase
    if (!idx_ok(rs1) || !idx_ok(rd) || (opcode == OPC_OP && !idx_ok(rs2))) d_legal = 1'b0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state: illegal words are swallowed in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && d_legal) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs; a reset landing in WB suppresses the retire and the write
  always_comb begin
    inst_ready   = (state == ST_IDLE);
    retire_valid = (state == ST_WB) && !rst;
    retire_rd    = retire_valid ? rd_q : '0;
    retire_data  = (retire_valid && rd_q != '0) ? result : '0;
  end

  // Datapath flops: ALU operands on accept, result at end of EXEC, illegal pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_funct3 <= '0;
      alu_funct7 <= '0;
      result     <= '0;
      rd_q       <= '0;
      illegal    <= 1'b0;
    end else begin
      illegal <= accept && !d_legal;
      if (accept && d_legal) begin
        alu_in1    <= rs1_data;
        alu_in2    <= d_in2;
        alu_funct3 <= f3;
        alu_funct7 <= d_f7;
        rd_q       <= rd;
      end
      if (state == ST_EXEC) result <= alu_out;
    end
  end

endmodule
